// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency SRAM model behind the MEM-stage data port.
// One word-aligned request per cycle. Each accepted request returns a single
// dmem_resp pulse, LATENCY cycles later, that carries the pre-write word.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp
);

  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int NUM_LANES = 4;
  // The counter only has to hold LATENCY-2. Keep it at least one bit wide.
  localparam int CW        = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  typedef struct packed {
    logic [DEPTH_LOG2-1:0] idx;
    logic [3:0]            rmask;
    logic [3:0]            wmask;
    logic [31:0]           wdata;
  } req_t;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  req_t              lat;
  logic              req, accept, complete;
  logic [31:0]       mem [DEPTH];

  assign req = (|dmem_rmask) || (|dmem_wmask);

  // Read enables are latched for visibility only. Byte selection happens in
  // write-back, and the upper address bits alias onto the array.
  logic unused_bits;
  assign unused_bits = ^{dmem_addr[31:DEPTH_LOG2+2], dmem_addr[1:0], lat.rmask};

  // State register: the FSM state and the remaining-wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state. On an accept edge the counter reloads; otherwise it counts down.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (accept) begin
      state_nxt = WAIT;
      cnt_nxt   = CW'(LATENCY - 2);
    end else if (complete) begin
      state_nxt = IDLE;
    end else if (state == WAIT) begin
      cnt_nxt   = cnt - CW'(1);
    end
  end

  // Outputs and strobes. The port can take a new request in the same cycle
  // that the pending access completes, which gives full throughput.
  always_comb begin
    dmem_ready = (state == IDLE) || (state == WAIT && cnt == '0);
    complete   = (state == WAIT) && (cnt == '0);
    accept     = req && dmem_ready;
  end

  // Request latch and response registers. Inputs are sampled only when a
  // request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat        <= '0;
      dmem_rdata <= '0;
      dmem_resp  <= 1'b0;
    end else begin
      dmem_resp <= complete;
      if (complete)
        dmem_rdata <= mem[lat.idx];
      if (accept)
        lat <= '{idx:   dmem_addr[DEPTH_LOG2+1:2],
                 rmask: dmem_rmask,
                 wmask: dmem_wmask,
                 wdata: dmem_wdata};
    end
  end

  // Array write. It commits only at the completion edge, so a reset during the
  // wait discards the access. Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (complete) begin
      for (int b = 0; b < NUM_LANES; b++)
        if (lat.wmask[b])
          mem[lat.idx][8*b +: 8] <= lat.wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder. There are three instances, at
// LATENCY 2, 4 and 3. The stimulus pushes the expected responses, and a
// negedge monitor pops them and checks data and arrival cycle.
module tb_dmem_responder;

  localparam int LAT [3] = '{2, 4, 3};

  typedef struct {
    int          inst;
    int          cyc;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn  [3];
  logic [31:0] addr  [3];
  logic [3:0]  rmask [3];
  logic [3:0]  wmask [3];
  logic [31:0] wdata [3];
  logic        ready [3];
  logic [31:0] rdata [3];
  logic        resp  [3];

  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb [$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u1 (
    .clk(clk), .rst_n(rstn[0]), .dmem_addr(addr[0]), .dmem_rmask(rmask[0]),
    .dmem_wmask(wmask[0]), .dmem_wdata(wdata[0]), .dmem_ready(ready[0]),
    .dmem_rdata(rdata[0]), .dmem_resp(resp[0]));

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u2 (
    .clk(clk), .rst_n(rstn[1]), .dmem_addr(addr[1]), .dmem_rmask(rmask[1]),
    .dmem_wmask(wmask[1]), .dmem_wdata(wdata[1]), .dmem_ready(ready[1]),
    .dmem_rdata(rdata[1]), .dmem_resp(resp[1]));

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(3)) u3 (
    .clk(clk), .rst_n(rstn[2]), .dmem_addr(addr[2]), .dmem_rmask(rmask[2]),
    .dmem_wmask(wmask[2]), .dmem_wdata(wdata[2]), .dmem_ready(ready[2]),
    .dmem_rdata(rdata[2]), .dmem_resp(resp[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one request for one cycle. Call it at posedge+1 of the request cycle.
  task automatic req(input int i, input logic [31:0] a, input logic [3:0] rm,
                     input logic [3:0] wm, input logic [31:0] wd,
                     input logic [31:0] ex, input bit c, input bit push = 1'b1);
    addr[i] = a; rmask[i] = rm; wmask[i] = wm; wdata[i] = wd;
    if (push) sb.push_back('{i, cyc + LAT[i], ex, c});
    @(posedge clk);
    #1;
    addr[i] = '0; rmask[i] = '0; wmask[i] = '0; wdata[i] = '0;
  endtask

  // Monitor: every response must match the head of the scoreboard, both in
  // data and in arrival cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (resp[i] === 1'b1) begin
        if (sb.size() == 0 || sb[0].inst != i) begin
          chk($sformatf("unexpected_resp_u%0d", i), 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("resp_cycle_u%0d", i), cyc, e.cyc);
          if (e.chk) chk($sformatf("rdata_u%0d", i), rdata[i], e.data);
        end
      end
    end
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk($sformatf("missing_resp_u%0d", sb[0].inst), 32'd0, 32'd1);
      void'(sb.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 1'b0; addr[i] = '0; rmask[i] = '0; wmask[i] = '0; wdata[i] = '0;
    end
    #3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ready_u%0d", i), 32'(ready[i]), 32'd1);
      chk($sformatf("reset_resp_u%0d", i), 32'(resp[i]), 32'd0);
      chk($sformatf("reset_rdata_u%0d", i), rdata[i], 32'd0);
    end
    #9;
    for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
    @(posedge clk);
    #1;

    // u1 (LATENCY 2): write, then read 4 cycles later.
    req(0, 32'h100, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
    idle(3);
    req(0, 32'h100, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
    idle(4);

    // Byte-lane write on lane 2. The partial write returns the pre-write word.
    req(0, 32'h40, 4'h0, 4'hF, 32'h11223344, 32'h0, 1'b0);
    req(0, 32'h40, 4'h0, 4'b0100, 32'h00AA0000, 32'h11223344, 1'b1);
    req(0, 32'h40, 4'hF, 4'h0, 32'h0, 32'h11AA3344, 1'b1);
    idle(3);

    // Back-to-back write then read of the same word. Ready stays high.
    chk("b2b_ready_c0", 32'(ready[0]), 32'd1);
    req(0, 32'h8, 4'h0, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
    chk("b2b_ready_c1", 32'(ready[0]), 32'd1);
    req(0, 32'h8, 4'hF, 4'h0, 32'h0, 32'hCAFEF00D, 1'b1);
    chk("b2b_ready_c2", 32'(ready[0]), 32'd1);
    idle(3);

    // Aliasing: upper address bits and byte offset are ignored.
    req(0, 32'h0000_100A, 4'hF, 4'h0, 32'h0, 32'hCAFEF00D, 1'b1);
    idle(3);

    // Combined read+write returns the old word. A later read sees the new one.
    req(0, 32'hC, 4'h0, 4'hF, 32'h01020304, 32'h0, 1'b0);
    req(0, 32'hC, 4'hF, 4'hF, 32'hFFFFFFFF, 32'h01020304, 1'b1);
    req(0, 32'hC, 4'hF, 4'h0, 32'h0, 32'hFFFFFFFF, 1'b1);
    idle(3);

    // u2 (LATENCY 4): a request while busy is dropped.
    req(1, 32'h10, 4'h0, 4'hF, 32'h0BADCAFE, 32'h0, 1'b0);
    idle(5);
    chk("busy_ready_c0", 32'(ready[1]), 32'd1);
    req(1, 32'h10, 4'hF, 4'h0, 32'h0, 32'h0BADCAFE, 1'b1);
    chk("busy_ready_c1", 32'(ready[1]), 32'd0);
    req(1, 32'h10, 4'h0, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    chk("busy_ready_c2", 32'(ready[1]), 32'd0);
    idle(1);
    chk("busy_ready_c3", 32'(ready[1]), 32'd1);
    idle(4);
    req(1, 32'h10, 4'hF, 4'h0, 32'h0, 32'h0BADCAFE, 1'b1);
    idle(6);

    // u3 (LATENCY 3): reset during a pending write discards it.
    req(2, 32'h20, 4'h0, 4'hF, 32'h13579BDF, 32'h0, 1'b0);
    idle(4);
    req(2, 32'h20, 4'h0, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b0);
    #1 rstn[2] = 1'b0;
    #1;
    chk("midrst_resp", 32'(resp[2]), 32'd0);
    chk("midrst_rdata", rdata[2], 32'd0);
    chk("midrst_ready", 32'(ready[2]), 32'd1);
    #1 rstn[2] = 1'b1;
    idle(6);
    req(2, 32'h20, 4'hF, 4'h0, 32'h0, 32'h13579BDF, 1'b1);
    idle(5);

    // Drain with a bound.
    begin
      int t = 0;
      while (sb.size() > 0 && t < 20) begin
        @(posedge clk);
        t++;
      end
    end
    if (sb.size() > 0) chk("drain_pending", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the pipeline's MEM-stage data port. Accepts one word-aligned request per cycle, as a read mask, write mask, or both, and models a fixed-latency SRAM behind that port. Returns a single-cycle `dmem_resp` pulse carrying `dmem_rdata` a fixed `LATENCY` cycles after the request. Used as the data-memory backing store in the core's top-level integration and in directed testbenches.

## Interface
- `DEPTH_LOG2`, 10, log2 of the number of 32-bit words in the array.
- `LATENCY`, 2, cycles from the request cycle to the `dmem_resp` cycle; legal range is ≥2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dmem_addr`  in  32  byte address; bits [1:0] ignored; word index = `dmem_addr[DEPTH_LOG2+1:2]`; upper bits ignored (aliasing).
- `dmem_rmask`  in  4  byte read enables; request present when nonzero.
- `dmem_wmask`  in  4  byte write enables; request present when nonzero.
- `dmem_wdata`  in  32  write data, byte lanes aligned to the word.
- `dmem_ready`  out  1  combinational; high when a request presented this cycle will be accepted.
- `dmem_rdata`  out  32  registered read data; valid only while `dmem_resp` is high.
- `dmem_resp`  out  1  registered, one-cycle completion pulse.

## Operation
- Request present (`req`) = `|dmem_rmask || |dmem_wmask`.
- Two-state FSM:
  - IDLE: no access pending.
  - WAIT: an access is pending; a counter `cnt` holds the remaining wait cycles.
- `dmem_ready` = (state == IDLE) || (state == WAIT && cnt == 0).
- Accept: at an edge where `req && dmem_ready`:
  - latch the word index, `rmask`, `wmask` and `wdata`;
  - load `cnt` = `LATENCY-2`;
  - go to WAIT.
- Request presented while `dmem_ready` is low: dropped silently; no state change, no response. The initiator must not do this.
- Complete: at an edge where state == WAIT && cnt == 0:
  - `dmem_rdata` <= the full latched word as read from the array before this edge's write;
  - the array is written on the byte lanes where latched `wmask` is set;
  - `dmem_resp` <= 1;
  - next state is WAIT if an accept occurs on the same edge, otherwise IDLE.
- WAIT with cnt != 0: `cnt` decrements each edge.
- `dmem_resp` <= 0 on every edge that does not complete an access.
- Read+write in one request: both are performed; `dmem_rdata` returns pre-write data.
- `dmem_rdata` is returned as the full 32-bit word regardless of `rmask`; byte selection and extension stay in the write-back stage.
- On a write-only completion, `dmem_rdata` still carries the pre-write word.
- Array contents are not reset. Simulation-only preload is allowed via `$readmemh` under a guarded initial block.

## Timing
- Reset values (async assert; deassert takes effect synchronously to `clk`): state = IDLE, `cnt` = 0, `dmem_resp` = 0, `dmem_rdata` = 0, latched request = 0. `dmem_ready` = 1 during reset.
- Reset mid-operation: the pending access is discarded. A pending write is never committed, because the write happens only at the completion edge, and no response is issued.
- Latency: request in cycle N, then `dmem_resp` is high in cycle N+LATENCY for exactly one cycle.
- Throughput: one request per cycle. A request in the cycle where `cnt` == 0 is accepted, so back-to-back requests yield back-to-back `dmem_resp` pulses.
- Ordering: responses return strictly in request order.
- Read-after-write to the same word on consecutive requests returns the new data, because the second access reads the array after the first has committed.
- Write data, masks and address are sampled only at the accept edge. Changes after acceptance have no effect.

## Test plan
- Single write then read, LATENCY=2.
  - Stimulus: word write `addr`=0x100, `wmask`=4'hF, `wdata`=0xDEADBEEF in cycle 0; read `rmask`=4'hF at 0x100 in cycle 4.
  - Response: `resp` high in cycle 2; `resp` high in cycle 6 with `rdata`=0xDEADBEEF.
- Byte-lane write.
  - Stimulus: preload 0x11223344 at 0x40; write `wmask`=4'b0100, `wdata`=0x00AA0000.
  - Response: a subsequent read returns 0x11AA3344.
- Back-to-back with forwarding order.
  - Stimulus: write 0xCAFEF00D to 0x8 in cycle 0; read 0x8 in cycle 1.
  - Response: `resp` in cycles 2 and 3; the cycle-3 `rdata`=0xCAFEF00D; `dmem_ready` stays high throughout.
- Combined read+write.
  - Stimulus: word holds 0x01020304; request with `rmask`=4'hF, `wmask`=4'hF, `wdata`=0xFFFFFFFF.
  - Response: `rdata`=0x01020304; a later read returns 0xFFFFFFFF.
- LATENCY=4 busy drop.
  - Stimulus: request in cycle 0; second request in cycle 1.
  - Response: `dmem_ready`=0 in cycles 1–2; the second request is dropped; exactly one `resp`, in cycle 4.
- Reset mid-write.
  - Stimulus: write 0x5A5A5A5A to 0x20 in cycle 0 (LATENCY=3); `rst_n` pulsed low in cycle 1.
  - Response: no `resp`; `dmem_rdata`=0; the word at 0x20 is unchanged on readback.
